// File: rtl/dmem_wbuf_responder.sv
// dmem_wbuf_responder: M-stage data memory with a posted write buffer and load forwarding.
// Rev 1.0 - initial release.
`default_nettype none

module dmem_wbuf_responder #(
   parameter int MEM_WORDS = 64,
   parameter int ADDR_BITS = 6,
   parameter int WB_DEPTH  = 4,
   parameter int CNT_BITS  = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                MemWriteM,
   input  logic                MemReadM,
   input  logic [31:0]         ALUOutM,
   input  logic [31:0]         WriteDataM,
   output logic [31:0]         ReadDataM,
   output logic                MemStallM,
   output logic                WbEmpty,
   output logic [CNT_BITS-1:0] WbCount
);
   localparam int PTR_BITS = $clog2(WB_DEPTH);

   logic [31:0]          mem       [MEM_WORDS];
   logic [ADDR_BITS-1:0] ent_idx   [WB_DEPTH];
   logic [31:0]          ent_data  [WB_DEPTH];
   logic [WB_DEPTH-1:0]  ent_valid;
   logic [PTR_BITS-1:0]  head;
   logic [PTR_BITS-1:0]  tail;
   logic [CNT_BITS-1:0]  count;

   logic [ADDR_BITS-1:0] idx;
   logic                 hit;
   logic [31:0]          fwd_data;
   logic [PTR_BITS-1:0]  pos;
   logic                 full;
   logic                 drain;
   logic                 push;
   logic                 unused_addr_bits;

   assign idx              = ALUOutM[ADDR_BITS+1:2];
   assign unused_addr_bits = &{1'b0, ALUOutM[31:ADDR_BITS+2], ALUOutM[1:0]};

   // Scan oldest to youngest so the last match left standing is the youngest entry.
   always_comb begin
      hit      = 1'b0;
      fwd_data = '0;
      pos      = head;
      for (int k = 0; k < WB_DEPTH; k++) begin
         pos = head + PTR_BITS'(k);
         if (ent_valid[pos] && (ent_idx[pos] == idx)) begin
            hit      = 1'b1;
            fwd_data = ent_data[pos];
         end
      end
   end

   assign full      = (count == CNT_BITS'(WB_DEPTH));
   assign drain     = (count != '0) && !(MemReadM && !hit);
   assign MemStallM = MemWriteM && full && !drain;
   assign push      = MemWriteM && !MemStallM;
   assign ReadDataM = !MemReadM ? 32'h0 : (hit ? fwd_data : mem[idx]);
   assign WbEmpty   = (count == '0);
   assign WbCount   = count;

   always_ff @(posedge clk) begin
      if (!reset) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         ent_valid <= '0;
      end else begin
         if (drain) begin
            ent_valid[head] <= 1'b0;
            head            <= head + PTR_BITS'(1);
         end
         // When full, push and pop hit the same slot; the push must win the valid bit.
         if (push) begin
            ent_valid[tail] <= 1'b1;
            ent_idx[tail]   <= idx;
            ent_data[tail]  <= WriteDataM;
            tail            <= tail + PTR_BITS'(1);
         end
         count <= count + CNT_BITS'(push) - CNT_BITS'(drain);
      end
   end

   // Reset discards buffered stores without letting the head one reach the RAM.
   always_ff @(posedge clk) begin
      if (reset && drain) begin
         mem[ent_idx[head]] <= ent_data[head];
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dmem_wbuf_responder.sv
// tb_dmem_wbuf_responder: directed vector table plus a drain-timing sequence.
// Rev 1.0 - initial release.
`default_nettype none

module tb_dmem_wbuf_responder;
   logic        clk = 1'b0;
   logic        reset;
   logic        MemWriteM;
   logic        MemReadM;
   logic [31:0] ALUOutM;
   logic [31:0] WriteDataM;
   logic [31:0] ReadDataM;
   logic        MemStallM;
   logic        WbEmpty;
   logic [2:0]  WbCount;

   int total = 0;
   int bad   = 0;

   dmem_wbuf_responder #(
      .MEM_WORDS(64), .ADDR_BITS(6), .WB_DEPTH(4), .CNT_BITS(3)
   ) dut (
      .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
      .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM),
      .MemStallM(MemStallM), .WbEmpty(WbEmpty), .WbCount(WbCount)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic        we;
      logic        re;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_stall;
      logic [2:0]  exp_cnt;
   } vec_t;

   vec_t vecs[$];

   localparam logic [31:0] A  = 32'h1111_0000, B = 32'h2222_0001, C = 32'h3333_0002;
   localparam logic [31:0] D  = 32'h4444_0003, G = 32'h5555_0004, E = 32'h6666_0005;
   localparam logic [31:0] H  = 32'h7777_0006, K = 32'h8888_0007, X = 32'h0BAD_F00D;
   localparam logic [31:0] P0 = 32'hC0DE_0000, P1 = 32'hC0DE_0001;
   localparam logic [31:0] P2 = 32'hC0DE_0002, P3 = 32'hC0DE_0003;
   localparam logic [31:0] V  = 32'hFACE_0000;
   localparam logic [31:0] DB = 32'hDEAD_BEEF;

   task automatic v(input logic rst_n, input logic we, input logic re,
                    input logic [31:0] addr, input logic [31:0] wd,
                    input logic [31:0] rd, input logic stall, input logic [2:0] cnt);
      vecs.push_back('{rst_n, we, re, addr, wd, rd, stall, cnt});
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst_n, input logic we, input logic re,
                        input logic [31:0] addr, input logic [31:0] wd);
      reset      = rst_n;
      MemWriteM  = we;
      MemReadM   = re;
      ALUOutM    = addr;
      WriteDataM = wd;
   endtask

   initial begin
      int cyc;

      // reset, we, re, addr, wdata  |  rd, stall, count (count/empty are pre-edge state)
      v(0,1,0,32'h10,32'h99, 0,0,0);
      v(1,0,0,32'h10,0,      0,0,0);
      v(1,1,0,32'h10,DB,     0,0,0);
      v(1,0,0,0,0,           0,0,1);
      v(1,0,1,32'h10,0,      DB,0,0);
      v(1,1,0,32'h80,X,      0,0,0);
      v(1,1,0,32'h00,P0,     0,0,1);
      v(1,1,0,32'h04,P1,     0,0,1);
      v(1,1,0,32'h08,P2,     0,0,1);
      v(1,1,0,32'h0C,P3,     0,0,1);
      v(1,0,0,0,0,           0,0,1);
      // fill: misses block the drain, duplicate idx 1 exercises youngest-hit
      v(1,1,0,32'h00,A,      0,0,0);
      v(1,1,1,32'h04,B,      P1,0,1);
      v(1,1,1,32'h08,C,      P2,0,2);
      v(1,1,1,32'h04,D,      B,0,3);
      v(1,1,1,32'h0C,G,      P3,0,3);
      v(1,0,1,32'h04,0,      D,0,4);
      v(1,1,1,32'h10,E,      DB,0,3);
      v(1,1,1,32'h80,K,      X,1,4);
      v(1,1,1,32'h80,K,      X,1,4);
      v(1,1,0,32'h80,K,      0,0,4);
      v(1,0,0,0,0,           0,0,4);
      v(1,0,0,0,0,           0,0,3);
      v(1,0,0,0,0,           0,0,2);
      v(1,0,0,0,0,           0,0,1);
      v(1,0,1,32'h00,0,      A,0,0);
      v(1,0,1,32'h04,0,      D,0,0);
      v(1,0,1,32'h08,0,      C,0,0);
      v(1,0,1,32'h0C,0,      G,0,0);
      v(1,0,1,32'h10,0,      E,0,0);
      v(1,0,1,32'h80,0,      K,0,0);
      // reset with three entries pending
      v(1,1,0,32'h00,H,      0,0,0);
      v(1,1,1,32'h04,H,      D,0,1);
      v(1,1,1,32'h08,H,      C,0,2);
      v(0,0,0,0,0,           0,0,3);
      v(1,0,1,32'h00,0,      A,0,0);
      v(1,0,1,32'h04,0,      D,0,0);
      v(1,0,1,32'h08,0,      C,0,0);
      // aliasing, byte offset, forwarding and same-cycle store invisibility
      v(1,1,0,32'h100,32'h55, 0,0,0);
      v(1,0,0,0,0,            0,0,1);
      v(1,0,1,32'h000,0,      32'h55,0,0);
      v(1,0,1,32'h003,0,      32'h55,0,0);
      v(1,1,0,32'h104,32'h66, 0,0,0);
      v(1,0,1,32'h007,0,      32'h66,0,1);
      v(1,0,1,32'h004,0,      32'h66,0,0);
      v(1,1,1,32'h008,32'h77, C,0,0);
      v(1,0,1,32'h008,0,      32'h77,0,1);
      v(1,0,0,0,0,            0,0,0);

      drive(0, 0, 0, 0, 0);
      @(negedge clk);

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].rst_n, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wd);
         #1;
         check($sformatf("v%0d.rd", i),    ReadDataM,        vecs[i].exp_rd);
         check($sformatf("v%0d.stall", i), 32'(MemStallM),   32'(vecs[i].exp_stall));
         check($sformatf("v%0d.cnt", i),   32'(WbCount),     32'(vecs[i].exp_cnt));
         check($sformatf("v%0d.empty", i), 32'(WbEmpty),     32'(vecs[i].exp_cnt == 3'd0));
      end

      // Fill four entries, then time the drain back to empty.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(1, 1, (i != 0), 32'h20 + 32'(4 * i), V + 32'(i));
         #1;
         check($sformatf("fill%0d.cnt", i), 32'(WbCount), 32'(i));
      end
      @(negedge clk);
      drive(1, 0, 0, 0, 0);
      #1;
      check("full.cnt", 32'(WbCount), 32'd4);
      cyc = 0;
      while (WbEmpty !== 1'b1 && cyc < 8) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      check("drain.cycles", 32'(cyc), 32'd4);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(1, 0, 1, 32'h20 + 32'(4 * i), 0);
         #1;
         check($sformatf("drained%0d.rd", i), ReadDataM, V + 32'(i));
      end

      @(negedge clk);
      drive(1, 0, 0, 0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
